// File: rtl/dma_pkg.sv
// Shared definitions for the descriptor dispatcher: descriptor layout,
// status-word bit positions and sequencer states.
package dma_pkg;

    localparam int DESC_W = 256;
    localparam int WORD_W = 32;

    // descriptor word indices
    localparam int W_SRC  = 0;
    localparam int W_DST  = 1;
    localparam int W_LEN  = 2;
    localparam int W_NEXT = 4;
    localparam int W_SELF = 5;
    localparam int W_CTRL = 7;

    // word7 control/status bits
    localparam int B_IRQ_EN = 0;
    localparam int B_OWNED  = 7;
    localparam int B_DONE   = 8;
    localparam int B_ERR    = 9;

    localparam int CSR_RUN = 5;

    localparam logic [WORD_W-1:0] WB_OFFSET = 32'h1C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_WB_WRITE,
        ST_HALT
    } state_e;

    function automatic logic [WORD_W-1:0] desc_word(input logic [DESC_W-1:0] d, input int idx);
        return d[idx*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/dma_desc_dispatch_if.sv
// Command channel to the transfer engine plus the AVMM writeback master.
// master = dispatcher side, slave = engine / descriptor memory side.
interface dma_desc_dispatch_if #(
    parameter int LEN_W = 24
);
    logic             cmd_valid_o;
    logic             cmd_ready_i;
    logic [31:0]      cmd_src_addr_o;
    logic [31:0]      cmd_dst_addr_o;
    logic [LEN_W-1:0] cmd_len_o;
    logic             xfer_done_i;
    logic             xfer_err_i;
    logic             dma_wb_write_o;
    logic [31:0]      dma_wb_addr_o;
    logic [31:0]      dma_wb_wrdata_o;
    logic             dma_wb_waitrequest_i;

    modport master (
        output cmd_valid_o, cmd_src_addr_o, cmd_dst_addr_o, cmd_len_o,
        output dma_wb_write_o, dma_wb_addr_o, dma_wb_wrdata_o,
        input  cmd_ready_i, xfer_done_i, xfer_err_i, dma_wb_waitrequest_i
    );

    modport slave (
        input  cmd_valid_o, cmd_src_addr_o, cmd_dst_addr_o, cmd_len_o,
        input  dma_wb_write_o, dma_wb_addr_o, dma_wb_wrdata_o,
        output cmd_ready_i, xfer_done_i, xfer_err_i, dma_wb_waitrequest_i
    );
endinterface

// File: rtl/dma_desc_dispatch.sv
// Descriptor sequencer: pop one descriptor, issue the copy command, wait for
// completion, write the status word back, then report to the CSR block.
module dma_desc_dispatch
    import dma_pkg::*;
#(
    parameter int LEN_W = 24,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          csr_control_i,
    input  logic                 dma_desc_fifo_empty_i,
    input  logic [DESC_W-1:0]    dma_desc_fifo_rddata_i,
    output logic                 dma_desc_fifo_rd_o,
    dma_desc_dispatch_if.master  bus,
    output logic                 busy_o,
    output logic                 irq_o,
    output logic                 err_o,
    output logic [CNT_W-1:0]     desc_count_o
);

    state_e              state_q, state_d;
    logic [DESC_W-1:0]   desc_q, desc_d;
    logic                xerr_q, xerr_d;
    logic                err_q, err_d;
    logic                irq_q, irq_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                run;
    logic [LEN_W-1:0]    head_len;
    logic                wb_accept;
    logic [31:0]         wb_data;

    assign run       = csr_control_i[CSR_RUN];
    assign head_len  = dma_desc_fifo_rddata_i[W_LEN*WORD_W +: LEN_W];
    assign wb_accept = (state_q == ST_WB_WRITE) && !bus.dma_wb_waitrequest_i;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (run && !dma_desc_fifo_empty_i) state_d = ST_LATCH;
            ST_LATCH:     state_d = (head_len == '0) ? ST_WB_WRITE : ST_ISSUE;
            ST_ISSUE:     if (bus.cmd_ready_i) state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (bus.xfer_err_i || bus.xfer_done_i) state_d = ST_WB_WRITE;
            ST_WB_WRITE:  if (!bus.dma_wb_waitrequest_i) state_d = xerr_q ? ST_HALT : ST_IDLE;
            ST_HALT:      if (!run) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Write back the control word with ownership returned to software.
    always_comb begin
        wb_data         = desc_word(desc_q, W_CTRL);
        wb_data[B_OWNED] = 1'b0;
        wb_data[B_DONE]  = ~xerr_q;
        wb_data[B_ERR]   = xerr_q;
    end

    // Outputs; payload buses are zero whenever their strobe is low.
    always_comb begin
        dma_desc_fifo_rd_o  = (state_q == ST_LATCH);
        bus.cmd_valid_o     = (state_q == ST_ISSUE);
        bus.dma_wb_write_o  = (state_q == ST_WB_WRITE);
        bus.cmd_src_addr_o  = '0;
        bus.cmd_dst_addr_o  = '0;
        bus.cmd_len_o       = '0;
        bus.dma_wb_addr_o   = '0;
        bus.dma_wb_wrdata_o = '0;
        if (state_q == ST_ISSUE) begin
            bus.cmd_src_addr_o = desc_word(desc_q, W_SRC);
            bus.cmd_dst_addr_o = desc_word(desc_q, W_DST);
            bus.cmd_len_o      = desc_q[W_LEN*WORD_W +: LEN_W];
        end
        if (state_q == ST_WB_WRITE) begin
            bus.dma_wb_addr_o   = desc_word(desc_q, W_SELF) + WB_OFFSET;
            bus.dma_wb_wrdata_o = wb_data;
        end
        busy_o       = (state_q != ST_IDLE);
        irq_o        = irq_q;
        err_o        = err_q;
        desc_count_o = cnt_q;
    end

    // Datapath next values
    always_comb begin
        desc_d = desc_q;
        xerr_d = xerr_q;
        err_d  = err_q;
        irq_d  = 1'b0;
        cnt_d  = cnt_q;
        case (state_q)
            ST_LATCH: begin
                desc_d = dma_desc_fifo_rddata_i;
                xerr_d = 1'b0;
            end
            // error outranks a simultaneous done pulse
            ST_WAIT_DONE: if (bus.xfer_err_i) xerr_d = 1'b1;
            ST_HALT:      if (!run) err_d = 1'b0;
            default: ;
        endcase
        if (wb_accept) begin
            cnt_d = cnt_q + 1'b1;
            irq_d = desc_q[W_CTRL*WORD_W + B_IRQ_EN] | xerr_q;
            if (xerr_q) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            desc_q <= '0;
            xerr_q <= 1'b0;
            err_q  <= 1'b0;
            irq_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            desc_q <= desc_d;
            xerr_q <= xerr_d;
            err_q  <= err_d;
            irq_q  <= irq_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_dma_desc_dispatch.sv
// Directed bench for dma_desc_dispatch (CNT_W=4 so the counter wrap is cheap).
module tb_dma_desc_dispatch;

    localparam int LEN_W = 24;
    localparam int CNT_W = 4;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [31:0]         csr_control = '0;
    logic                fifo_empty;
    logic [255:0]        fifo_rddata;
    logic                fifo_rd;
    logic                busy, irq, err;
    logic [CNT_W-1:0]    count;

    dma_desc_dispatch_if #(.LEN_W(LEN_W)) bus ();

    dma_desc_dispatch #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .csr_control_i         (csr_control),
        .dma_desc_fifo_empty_i (fifo_empty),
        .dma_desc_fifo_rddata_i(fifo_rddata),
        .dma_desc_fifo_rd_o    (fifo_rd),
        .bus                   (bus),
        .busy_o                (busy),
        .irq_o                 (irq),
        .err_o                 (err),
        .desc_count_o          (count)
    );

    always #5 clk = ~clk;

    // Show-ahead FIFO model: initial block writes mem/wr_ptr, monitor advances rd_ptr.
    logic [255:0] mem [0:31];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty  = (rd_ptr == wr_ptr);
    assign fifo_rddata = mem[rd_ptr[4:0]];

    int n_cmd = 0, n_wr = 0, n_irq = 0;
    int n_chk = 0, n_err = 0;

    always @(posedge clk) begin
        if (fifo_rd) rd_ptr <= rd_ptr + 1;
        if (bus.cmd_valid_o && bus.cmd_ready_i) n_cmd <= n_cmd + 1;
        if (bus.dma_wb_write_o && !bus.dma_wb_waitrequest_i) n_wr <= n_wr + 1;
        if (irq) n_irq <= n_irq + 1;
    end

    function automatic logic [255:0] mk(input logic [31:0] src, input logic [31:0] dst,
                                        input logic [31:0] len, input logic [31:0] self_a,
                                        input logic [31:0] ctrl);
        logic [255:0] d;
        d = '0;
        d[31:0]    = src;
        d[63:32]   = dst;
        d[95:64]   = len;
        d[191:160] = self_a;
        d[255:224] = ctrl;
        return d;
    endfunction

    task automatic push(input logic [255:0] d);
        mem[wr_ptr[4:0]] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // sel: 0 cmd_valid, 1 wb write
    task automatic wait_on(input int sel, input string tag);
        int k;
        logic hit;
        k = 0;
        hit = (sel == 0) ? bus.cmd_valid_o : bus.dma_wb_write_o;
        while (!hit && k < 50) begin
            tick();
            k++;
            hit = (sel == 0) ? bus.cmd_valid_o : bus.dma_wb_write_o;
        end
        if (!hit) chk(tag, 0, 1);
    endtask

    initial begin
        bus.cmd_ready_i = 1'b1;
        bus.xfer_done_i = 1'b0;
        bus.xfer_err_i = 1'b0;
        bus.dma_wb_waitrequest_i = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = '0;

        // reset state
        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_irq", irq, 0);
        chk("rst_err", err, 0);
        chk("rst_count", count, 0);
        chk("rst_rd", fifo_rd, 0);
        chk("rst_cmd_valid", bus.cmd_valid_o, 0);
        chk("rst_wb_write", bus.dma_wb_write_o, 0);
        reset = 1'b1;
        tick();

        // normal descriptor
        push(mk(32'h1000, 32'h2000, 32'h40, 32'h8000, 32'h81));
        csr_control = 32'h20;
        wait_on(0, "norm_cmd_timeout");
        chk("norm_src", bus.cmd_src_addr_o, 32'h1000);
        chk("norm_dst", bus.cmd_dst_addr_o, 32'h2000);
        chk("norm_len", bus.cmd_len_o, 24'h40);
        tick(10);
        bus.xfer_done_i = 1'b1;
        tick();
        bus.xfer_done_i = 1'b0;
        wait_on(1, "norm_wb_timeout");
        chk("norm_wb_addr", bus.dma_wb_addr_o, 32'h801C);
        chk("norm_wb_data", bus.dma_wb_wrdata_o, 32'h101);
        tick();
        chk("norm_irq", irq, 1);
        chk("norm_count", count, 1);
        chk("norm_busy", busy, 0);
        chk("norm_ncmd", n_cmd, 1);
        chk("norm_npop", rd_ptr, 1);
        tick();
        chk("norm_irq_pulse", irq, 0);

        // zero length: no command, no interrupt
        push(mk(32'h0, 32'h0, 32'h0, 32'h9000, 32'h80));
        wait_on(1, "zero_wb_timeout");
        chk("zero_wb_addr", bus.dma_wb_addr_o, 32'h901C);
        chk("zero_wb_data", bus.dma_wb_wrdata_o, 32'h100);
        tick(3);
        chk("zero_ncmd", n_cmd, 1);
        chk("zero_nirq", n_irq, 1);
        chk("zero_count", count, 2);

        // transfer error with done in the same cycle; second entry queued
        push(mk(32'hA0, 32'hB0, 32'h8, 32'hA000, 32'h80));
        push(mk(32'h3000, 32'h4000, 32'h100, 32'hB000, 32'h80));
        bus.cmd_ready_i = 1'b0;
        bus.dma_wb_waitrequest_i = 1'b1;
        wait_on(0, "err_cmd_timeout");
        bus.cmd_ready_i = 1'b1;
        tick(2);
        bus.xfer_done_i = 1'b1;
        bus.xfer_err_i = 1'b1;
        tick();
        bus.xfer_done_i = 1'b0;
        bus.xfer_err_i = 1'b0;
        bus.dma_wb_waitrequest_i = 1'b0;
        wait_on(1, "err_wb_timeout");
        chk("err_wb_data", bus.dma_wb_wrdata_o, 32'h200);
        tick();
        chk("err_irq", irq, 1);
        chk("err_sticky", err, 1);
        tick(5);
        chk("err_halt_busy", busy, 1);
        chk("err_no_pop", rd_ptr, 3);
        chk("err_hold", err, 1);
        bus.cmd_ready_i = 1'b0;
        bus.dma_wb_waitrequest_i = 1'b1;
        csr_control = 32'h0;
        tick();
        chk("err_clear", err, 0);
        chk("err_idle", busy, 0);

        // backpressure on command and writeback; stray done in ISSUE ignored
        csr_control = 32'h20;
        wait_on(0, "bp_cmd_timeout");
        for (int i = 0; i < 5; i++) begin
            chk("bp_cmd_valid", bus.cmd_valid_o, 1);
            chk("bp_cmd_src", bus.cmd_src_addr_o, 32'h3000);
            chk("bp_cmd_len", bus.cmd_len_o, 24'h100);
            bus.xfer_done_i = (i == 2);
            tick();
        end
        bus.xfer_done_i = 1'b0;
        chk("bp_cmd_still", bus.cmd_valid_o, 1);
        bus.cmd_ready_i = 1'b1;
        tick();
        bus.cmd_ready_i = 1'b0;
        tick(2);
        bus.xfer_done_i = 1'b1;
        tick();
        bus.xfer_done_i = 1'b0;
        wait_on(1, "bp_wb_timeout");
        for (int i = 0; i < 3; i++) begin
            chk("bp_wb_write", bus.dma_wb_write_o, 1);
            chk("bp_wb_addr", bus.dma_wb_addr_o, 32'hB01C);
            chk("bp_wb_data", bus.dma_wb_wrdata_o, 32'h100);
            tick();
        end
        bus.dma_wb_waitrequest_i = 1'b0;
        tick();
        chk("bp_npop", rd_ptr, 4);
        chk("bp_ncmd", n_cmd, 3);
        chk("bp_nwr", n_wr, 4);
        chk("bp_irq", irq, 0);
        chk("bp_count", count, 4);

        // run cleared mid-descriptor: finishes, then stops popping
        bus.cmd_ready_i = 1'b1;
        push(mk(32'h5000, 32'h6000, 32'h4, 32'hC000, 32'h01));
        push(mk(32'h0, 32'h0, 32'h0, 32'hD000, 32'h80));
        wait_on(0, "stop_cmd_timeout");
        tick();
        csr_control = 32'h0;
        tick(2);
        bus.xfer_done_i = 1'b1;
        tick();
        bus.xfer_done_i = 1'b0;
        wait_on(1, "stop_wb_timeout");
        chk("stop_wb_addr", bus.dma_wb_addr_o, 32'hC01C);
        chk("stop_wb_data", bus.dma_wb_wrdata_o, 32'h101);
        tick();
        chk("stop_irq", irq, 1);
        tick(3);
        chk("stop_busy", busy, 0);
        chk("stop_npop", rd_ptr, 5);
        chk("stop_count", count, 5);

        // counter wrap: 11 more completions bring the 4-bit count to 16 -> 0
        for (int i = 0; i < 10; i++) push(mk(32'h0, 32'h0, 32'h0, 32'hE000 + i * 32'h20, 32'h80));
        csr_control = 32'h20;
        begin
            int k;
            k = 0;
            tick();
            while ((rd_ptr != wr_ptr || busy) && k < 400) begin
                tick();
                k++;
            end
            chk("wrap_drained", (rd_ptr == wr_ptr) && !busy, 1);
        end
        chk("wrap_count", count, 0);
        chk("wrap_nwr", n_wr, 16);

        // reset mid-command abandons it
        bus.cmd_ready_i = 1'b0;
        push(mk(32'h7000, 32'h7100, 32'h10, 32'hF000, 32'h81));
        wait_on(0, "rstmid_cmd_timeout");
        reset = 1'b0;
        tick();
        chk("rstmid_cmd_valid", bus.cmd_valid_o, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_count", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/dma_desc_dispatch.md
Name: dma_desc_dispatch

Overview:
Sequencer between the descriptor FIFO and the DMA transfer engine. It pops one 256-bit descriptor, issues a copy command to the read/write engine and waits for completion. It then writes the updated status word back to descriptor memory over an AVMM write master. Completion, error and interrupt status are reported to the CSR block.

Parameters:
LEN_W, 24, width of transfer length field (bytes), taken from word2[LEN_W-1:0]
CNT_W, 16, width of completed-descriptor counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
csr_control_i  in  32  CSR control; bit5 = run
dma_desc_fifo_empty_i  in  1  descriptor FIFO empty
dma_desc_fifo_rddata_i  in  256  show-ahead FIFO head (valid while ~empty)
dma_desc_fifo_rd_o  out  1  pop strobe
cmd_valid_o  out  1  transfer command valid
cmd_ready_i  in  1  engine accepts command
cmd_src_addr_o  out  32  source address (word0)
cmd_dst_addr_o  out  32  destination address (word1)
cmd_len_o  out  LEN_W  byte count (word2)
xfer_done_i  in  1  one-cycle completion pulse from engine
xfer_err_i  in  1  one-cycle error pulse from engine
dma_wb_write_o  out  1  AVMM write request
dma_wb_addr_o  out  32  writeback address
dma_wb_wrdata_o  out  32  writeback data
dma_wb_waitrequest_i  in  1  AVMM waitrequest
busy_o  out  1  state != IDLE
irq_o  out  1  one-cycle interrupt pulse
err_o  out  1  sticky error, cleared when run deasserts
desc_count_o  out  CNT_W  descriptors completed (wraps)

Behaviour:
- Descriptor words are 32 bits, word0 at bits [31:0]. word0 = src, word1 = dst, word2 = length, word4 = next pointer (ignored here), word5 = own address (software-written), word7 = control/status.
- word7 fields: bit0 irq_en, bit7 owned_by_hw, bit8 done, bit9 error.
- Reset (reset==0): state IDLE, all outputs 0, descriptor register 0, err_o 0, desc_count_o 0.
- States are IDLE, LATCH, ISSUE, WAIT_DONE, WB_WRITE, HALT.
- IDLE: when run & ~empty, go to LATCH. Otherwise stay.
- LATCH (1 cycle):
  - dma_desc_fifo_rd_o=1 and the full 256 bits are registered.
  - If len==0 go to WB_WRITE with done set and no command issued; else go to ISSUE.
- ISSUE:
  - cmd_valid_o=1 with src/dst/len stable from the register.
  - Hold until cmd_ready_i, then go to WAIT_DONE. Valid must not drop before ready.
- WAIT_DONE:
  - xfer_err_i: set the error flag, go to WB_WRITE.
  - Else xfer_done_i: go to WB_WRITE.
  - If both are asserted in the same cycle, error wins.
- Pulses on xfer_done_i/xfer_err_i outside WAIT_DONE are ignored.
- WB_WRITE:
  - dma_wb_write_o=1, addr = word5 + 32'h1C.
  - data = word7 with bit7=0, bit8=~error, bit9=error.
  - Hold addr/data stable until ~waitrequest.
  - On the accept cycle: desc_count_o+1 (wrapping). irq_o pulses on the next cycle if irq_en or error.
  - Then go to HALT if error (err_o<=1), else IDLE.
- HALT: stay until run==0, then clear err_o and go to IDLE.
- Run deasserted mid-descriptor: the current descriptor completes, including writeback; no abort. IDLE then does not pop further.
- Throughput: minimum 4 cycles per descriptor (LATCH, ISSUE, WAIT_DONE, WB_WRITE) plus one IDLE cycle.
- Reset asserted mid-operation: immediate return to IDLE, with the outstanding command or write abandoned.

Decomposition:
- Shared package dma_pkg holds:
  - descriptor word-index constants (SRC=0, DST=1, LEN=2, NEXT=4, SELF=5, CTRL=7);
  - word7 bit positions (IRQ_EN=0, OWNED=7, DONE=8, ERR=9);
  - CSR run bit index (5);
  - writeback offset 32'h1C;
  - state enum.
- No sub-module required. Optionally factor the writeback AVMM single-write handshake as dma_avmm_single_wr.

Test Plan:
- Normal descriptor: FIFO head src=0x1000, dst=0x2000, len=0x40, word5=0x8000, word7=0x81, run=1, cmd_ready immediate, xfer_done 10 cycles later -> one cmd with those values; write to 0x801C data 0x101; irq_o pulse; desc_count_o=1.
- Zero length: len=0, word7=0x80 -> no cmd_valid_o; writeback data 0x100; no irq_o.
- Transfer error: xfer_err_i and xfer_done_i together, word7=0x80 -> writeback data 0x200; irq_o pulse; err_o=1; next FIFO entry not popped until run=0, then err_o=0.
- Backpressure: cmd_ready_i low 5 cycles, waitrequest high 3 cycles -> cmd_valid_o, dma_wb_write_o, addr and data held stable throughout; exactly one pop, one command, one write.
- Run cleared during WAIT_DONE with 2 entries queued -> first descriptor completes and is written back; second not popped; busy_o=0.
- Counter wrap: preload via 2^CNT_W completions (CNT_W=4 build, 16 descriptors) -> desc_count_o returns to 0.
